descriptor_memory_arb: RTL and testbench
========================================

# descriptor_memory_arb

Parametrised on-chip descriptor memory with two Avalon-MM slave ports, s1 for the CPU and s2 for the SG-DMA, sharing one single-port RAM array. A round-robin arbiter grants one access per cycle and stalls the loser with waitrequest. Reads are pipelined with a fixed latency and flagged by readdatavalid. It replaces the fixed 32x1024 unregistered-output descriptor RAM in the SOPC system.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width; depth = 2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read grant to readdatavalid; legal values are 1 and 2.
- INIT_FILE, "descriptor_memory.hex", power-up contents; not reapplied on reset.

Ports (sN = s1, s2; identical sets):
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  global clock enable.
- reset_req  in  1  when high, the RAM is frozen; effective enable is clken & ~reset_req.
- sN_address  in  ADDR_WIDTH  word address.
- sN_byteenable  in  DATA_WIDTH/8  write byte lanes.
- sN_chipselect, sN_read, sN_write  in  1 each  Avalon-MM controls.
- sN_writedata  in  DATA_WIDTH  write data.
- sN_readdata  out  DATA_WIDTH  read data; valid only when sN_readdatavalid is high.
- sN_readdatavalid  out  1  one-cycle pulse per completed read.
- sN_waitrequest  out  1  combinational stall.
- parity_error  out  1  sticky parity error flag (see Configuration).

## Operation
- Request: reqN = sN_chipselect & (sN_read | sN_write). If read and write are both high, the access is a write and the read is ignored.
- Enable: en = clken & ~reset_req.
- Arbitration (en high):
  - One request only: that port is granted.
  - Both ports requesting: the grant goes to the port not granted last.
  - last_grant updates only on an actual grant. Its reset value is s2, so s1 wins the first tie.
- sN_waitrequest = reqN & ~grantN. With en low, every requesting port sees waitrequest high and nothing is granted.
- Granted write: the enabled byte lanes are written at that clock edge. Disabled lanes are unchanged.
- Granted read: the address is registered and the data returns on the granting port only.
  - The read pipeline carries a valid bit and a port tag per stage.
  - While en is low the pipeline holds its state and both readdatavalid outputs are 0. It resumes when en returns high.
- Read of an address written in an earlier cycle returns the new data. A same-cycle collision is impossible because the arbiter grants one access per cycle.
- Reset (asynchronous):
  - All pipeline valid bits clear; in-flight reads are dropped and never signalled.
  - readdata = 0, readdatavalid = 0, last_grant = s2, parity_error = 0.
  - RAM contents are retained.

## Timing
- Write: committed at the grant edge; zero-wait when uncontested.
- Read, READ_LATENCY=1: request granted in cycle T, readdatavalid high in cycle T+1.
- Read, READ_LATENCY=2: readdatavalid high in cycle T+2 (output register stage added).
- Throughput: one access per enabled cycle. Under continuous contention the ports alternate, so each gets 50%.
- Back-to-back reads on one port produce back-to-back readdatavalid pulses, in order.

## Configuration
- DESCRIPTOR_MEMORY_PARITY_EN:
  - Defined: one even-parity bit is stored per byte and written with its lane. Every completed read checks all lanes. Any mismatch sets parity_error in the same cycle as readdatavalid; it stays set until reset. Data is delivered unmodified.
  - Undefined: no parity storage, and parity_error is tied to 0. The port list is identical in both builds.

## Test plan
- Single-port write then read: s1 writes 0xDEADBEEF to address 5 with byteenable 0xF, then reads address 5. Required: readdata 0xDEADBEEF with readdatavalid exactly READ_LATENCY cycles after the grant, and waitrequest never high.
- Byte lanes: address 5 holds 0xDEADBEEF; write 0x11223344 with byteenable 0x5. A read of address 5 returns 0xDE22BE44.
- Contention: s1 and s2 request every cycle for 6 cycles from reset. Required grant sequence s1,s2,s1,s2,s1,s2, with waitrequest high on the non-granted port each cycle.
- Stall: deassert clken for 3 cycles while a READ_LATENCY=2 read is in flight. Required: no readdatavalid during the stall, then data delivered 2 enabled cycles after the grant. Repeat with reset_req high for the stall; behaviour is identical.
- Reset mid-read: assert reset the cycle after an s2 read grant. Required: no s2_readdatavalid afterwards, readdata 0, and the next tie won by s1.
- Parity (macro defined): write address 7, force one stored data bit to flip, then read address 7. Required: parity_error rises together with readdatavalid and stays high until reset.

Source files
------------

// File: rtl/descriptor_memory_arb.sv
// -----------------------------------------------------------------------------
// descriptor_memory_arb
//
// On-chip descriptor memory shared by two Avalon-MM slave ports: s1 (CPU) and
// s2 (SG-DMA). Both ports address one single-port RAM array. A round-robin
// arbiter grants at most one access per enabled cycle and stalls the losing
// port with a combinational waitrequest. Reads are pipelined with a fixed
// latency of READ_LATENCY (1 or 2) and are flagged by a one-cycle
// readdatavalid pulse on the port that issued them.
//
// Optional feature macro: DESCRIPTOR_MEMORY_PARITY_EN
//   Defined   : one even-parity bit is stored per byte lane. Every completed
//               read checks all lanes and a mismatch raises the sticky
//               parity_error flag in the same cycle as readdatavalid.
//   Undefined : no parity storage; parity_error is tied low.
//
// Parameters:
//   DATA_WIDTH   word width, multiple of 8
//   ADDR_WIDTH   word address width, depth = 2**ADDR_WIDTH
//   READ_LATENCY cycles from read grant to readdatavalid (1 or 2)
//   INIT_FILE    name of the power-up image handed to the device memory
//                initialisation flow; the array is never cleared by reset
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   clken, reset_req    effective enable = clken & ~reset_req; with the
//                       enable low nothing is granted and the read pipeline
//                       holds its state
//   sN_address          word address              (N = 1, 2)
//   sN_byteenable       write byte lanes
//   sN_chipselect/read/write  Avalon-MM controls (write wins over read)
//   sN_writedata        write data
//   sN_readdata         read data, zero unless sN_readdatavalid is high
//   sN_readdatavalid    one-cycle pulse per completed read
//   sN_waitrequest      combinational stall
//   parity_error        sticky parity error flag
// -----------------------------------------------------------------------------
module descriptor_memory_arb #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "descriptor_memory.hex"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic                      reset_req,

    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,
    output logic                      s1_waitrequest,

    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,
    output logic                      s2_waitrequest,

    output logic                      parity_error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic en;
    logic req1;
    logic req2;
    logic grant1;
    logic grant2;
    logic grant_any;
    logic last_grant_reg;   // 0 = s1 granted last, 1 = s2 granted last

    assign en   = clken & ~reset_req;
    assign req1 = s1_chipselect & (s1_read | s1_write);
    assign req2 = s2_chipselect & (s2_read | s2_write);

    // On a tie the port that was not granted last wins.
    assign grant1    = en & req1 & (~req2 | last_grant_reg);
    assign grant2    = en & req2 & (~req1 | ~last_grant_reg);
    assign grant_any = grant1 | grant2;

    assign s1_waitrequest = req1 & ~grant1;
    assign s2_waitrequest = req2 & ~grant2;

    // Reset value s2 lets s1 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (grant_any) begin
            last_grant_reg <= grant2;
        end
    end

    // -------------------------------------------------------------------------
    // Granted access mux
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [BYTES-1:0]        acc_be;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_write;
    logic                    do_write;
    logic                    do_read;
    logic [BYTES-1:0][7:0]   wdata_lanes;

    assign acc_addr    = grant1 ? s1_address    : s2_address;
    assign acc_be      = grant1 ? s1_byteenable : s2_byteenable;
    assign acc_wdata   = grant1 ? s1_writedata  : s2_writedata;
    assign acc_write   = grant1 ? s1_write      : s2_write;
    assign wdata_lanes = acc_wdata;

    // A granted request is a write if write is high, otherwise a read.
    assign do_write = grant_any & acc_write;
    assign do_read  = grant_any & ~acc_write;

    // -------------------------------------------------------------------------
    // RAM array with registered read. No reset: contents survive reset.
    // -------------------------------------------------------------------------
    logic [BYTES-1:0][7:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (acc_be[b]) begin
                    mem[acc_addr][b] <= wdata_lanes[b];
                end
            end
        end
        if (do_read) begin
            ram_q <= mem[acc_addr];
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline: valid bit and port tag per stage (tag 0 = s1, 1 = s2).
    // Every stage advances only on enabled cycles, so a stall freezes reads
    // in place rather than dropping them.
    // -------------------------------------------------------------------------
    logic rd_valid1_reg;
    logic rd_tag1_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid1_reg <= 1'b0;
            rd_tag1_reg   <= 1'b0;
        end else if (en) begin
            rd_valid1_reg <= do_read;
            if (do_read) begin
                rd_tag1_reg <= grant2;
            end
        end
    end

    logic                  out_valid;
    logic                  out_tag;
    logic [DATA_WIDTH-1:0] out_data;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_valid2_reg;
            logic                  rd_tag2_reg;
            logic [DATA_WIDTH-1:0] rd_data2_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_valid2_reg <= 1'b0;
                    rd_tag2_reg   <= 1'b0;
                    rd_data2_reg  <= '0;
                end else if (en) begin
                    rd_valid2_reg <= rd_valid1_reg;
                    rd_tag2_reg   <= rd_tag1_reg;
                    rd_data2_reg  <= ram_q;
                end
            end

            assign out_valid = rd_valid2_reg;
            assign out_tag   = rd_tag2_reg;
            assign out_data  = rd_data2_reg;
        end else begin : g_lat1
            assign out_valid = rd_valid1_reg;
            assign out_tag   = rd_tag1_reg;
            assign out_data  = ram_q;
        end
    endgenerate

    // A held read is only presented on an enabled cycle; the pipeline then
    // advances at that edge, so each read pulses exactly once.
    logic rd_pulse;

    assign rd_pulse         = out_valid & en;
    assign s1_readdatavalid = rd_pulse & ~out_tag;
    assign s2_readdatavalid = rd_pulse &  out_tag;
    assign s1_readdata      = s1_readdatavalid ? out_data : '0;
    assign s2_readdata      = s2_readdatavalid ? out_data : '0;

    // -------------------------------------------------------------------------
    // Optional per-byte even parity
    // -------------------------------------------------------------------------
`ifdef DESCRIPTOR_MEMORY_PARITY_EN
    genvar gi;

    logic [BYTES-1:0] par_mem [DEPTH];
    logic [BYTES-1:0] wr_par;
    logic [BYTES-1:0] par_q;
    logic [BYTES-1:0] out_par;
    logic [BYTES-1:0] lane_bad;
    logic             parity_error_reg;

    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_par_lane
            // Even parity: stored bit equals the XOR of the lane's data bits.
            assign wr_par[gi]   = ^wdata_lanes[gi];
            assign lane_bad[gi] = (^out_data[gi*8 +: 8]) ^ out_par[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (acc_be[b]) begin
                    par_mem[acc_addr][b] <= wr_par[b];
                end
            end
        end
        if (do_read) begin
            par_q <= par_mem[acc_addr];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_par_lat2
            logic [BYTES-1:0] par2_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    par2_reg <= '0;
                end else if (en) begin
                    par2_reg <= par_q;
                end
            end

            assign out_par = par2_reg;
        end else begin : g_par_lat1
            assign out_par = par_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_error_reg <= 1'b0;
        end else if (rd_pulse && (|lane_bad)) begin
            parity_error_reg <= 1'b1;
        end
    end

    // The combinational term makes the flag rise with readdatavalid; the
    // register keeps it high afterwards.
    assign parity_error = parity_error_reg | (rd_pulse & (|lane_bad));
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_descriptor_memory_arb.sv
module tb_descriptor_memory_arb;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LAT   = 2;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clken = 1'b1;
    logic reset_req = 1'b0;

    logic [1:0]          cs;
    logic [1:0]          rd;
    logic [1:0]          wr;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][BW-1:0]  be;
    logic [1:0][DW-1:0]  wd;
    logic [1:0][DW-1:0]  rdata;
    logic [1:0]          rvalid;
    logic [1:0]          wait_r;
    logic                parity_error;

    always #5 clk = ~clk;

    descriptor_memory_arb #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clken            (clken),
        .reset_req        (reset_req),
        .s1_address       (addr[0]),
        .s1_byteenable    (be[0]),
        .s1_chipselect    (cs[0]),
        .s1_read          (rd[0]),
        .s1_write         (wr[0]),
        .s1_writedata     (wd[0]),
        .s1_readdata      (rdata[0]),
        .s1_readdatavalid (rvalid[0]),
        .s1_waitrequest   (wait_r[0]),
        .s2_address       (addr[1]),
        .s2_byteenable    (be[1]),
        .s2_chipselect    (cs[1]),
        .s2_read          (rd[1]),
        .s2_write         (wr[1]),
        .s2_writedata     (wd[1]),
        .s2_readdata      (rdata[1]),
        .s2_readdatavalid (rvalid[1]),
        .s2_waitrequest   (wait_r[1]),
        .parity_error     (parity_error)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int            due;    // enabled-cycle index in which data must appear
        logic [DW-1:0] data;
        bit            bad;    // stored word has a corrupted lane-0 bit
    } rd_t;

    rd_t           rq [2][$];
    logic [DW-1:0] mm [DEPTH];
    bit            corrupt [DEPTH];
    int            m_last = 1;      // port index granted last
    int            ecount = 0;      // number of enabled clock edges so far
    bit            m_perr = 0;

    // Observed values of the most recent step
    logic [1:0]          obs_v;
    logic [1:0]          obs_w;
    logic [1:0][DW-1:0]  obs_d;
    logic                obs_pe;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input bit c, input bit r_, input bit w_,
                         input int a, input logic [BW-1:0] b, input logic [DW-1:0] d);
        cs[p]   = c;
        rd[p]   = r_;
        wr[p]   = w_;
        addr[p] = a[AW-1:0];
        be[p]   = b;
        wd[p]   = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, 0, '0, '0);
    endtask

    // One clock cycle: called just after a rising edge with inputs driven.
    // Samples at the falling edge, checks against the model, then advances
    // the model across the next rising edge.
    task automatic step();
        bit       en;
        bit [1:0] r;
        bit [1:0] g;
        bit       pe_now;
        pe_now = 0;
        @(negedge clk);
        if (reset) begin
            rq[0].delete();
            rq[1].delete();
            m_last = 1;
            m_perr = 0;
        end
        en = clken && !reset_req;
        for (int i = 0; i < 2; i++) r[i] = cs[i] && (rd[i] || wr[i]);
        g[0] = en && r[0] && (!r[1] || m_last == 1);
        g[1] = en && r[1] && (!r[0] || m_last == 0);

        for (int i = 0; i < 2; i++) begin
            bit            ev;
            bit            bad;
            logic [DW-1:0] ed;
            ev  = 0;
            bad = 0;
            ed  = '0;
            if (!reset && en && rq[i].size() > 0 && rq[i][0].due == ecount) begin
                ev  = 1;
                ed  = rq[i][0].data;
                bad = rq[i][0].bad;
                void'(rq[i].pop_front());
            end
            obs_v[i] = rvalid[i];
            obs_w[i] = wait_r[i];
            obs_d[i] = rdata[i];
            chk($sformatf("s%0d_readdatavalid@%0d", i + 1, ecount), rvalid[i], ev);
            if (ev) chk($sformatf("s%0d_readdata@%0d", i + 1, ecount), rdata[i], ed);
            if (reset) chk($sformatf("s%0d_readdata_in_reset", i + 1), rdata[i], '0);
            chk($sformatf("s%0d_waitrequest@%0d", i + 1, ecount), wait_r[i], r[i] && !g[i]);
            if (ev && bad) pe_now = 1;
        end
        obs_pe = parity_error;
        chk("parity_error", parity_error, m_perr | pe_now);
        m_perr = m_perr | pe_now;

        if (!reset && en) begin
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    if (wr[i]) begin
                        for (int b = 0; b < BW; b++)
                            if (be[i][b]) mm[addr[i]][b*8 +: 8] = wd[i][b*8 +: 8];
                        if (be[i][0]) corrupt[addr[i]] = 0;
                    end else begin
                        rq[i].push_back('{due: ecount + LAT, data: mm[addr[i]], bad: corrupt[addr[i]]});
                    end
                end
            end
            if (g != 2'b00) m_last = g[1] ? 1 : 0;
            ecount++;
        end
        @(posedge clk);
        #1;
    endtask

    // Read address 5 on s1, stall the enable for 3 cycles, measure latency.
    task automatic stall_read(input string tag, input bit use_rr);
        int n;
        idle();
        drive(0, 1, 1, 0, 5, '1, '0);
        step();
        chk({tag, "_grant_wait"}, obs_w[0], 1'b0);
        idle();
        if (use_rr) reset_req = 1'b1;
        else        clken = 1'b0;
        repeat (3) begin
            step();
            chk({tag, "_no_valid_in_stall"}, obs_v[0], 1'b0);
        end
        clken     = 1'b1;
        reset_req = 1'b0;
        n = 0;
        while (n < 8) begin
            step();
            n++;
            if (obs_v[0]) break;
        end
        chk({tag, "_enabled_cycles_to_valid"}, n, 2);
        chk({tag, "_data"}, obs_d[0], 32'hDE22BE44);
    endtask

    initial begin
        idle();
        for (int a = 0; a < DEPTH; a++) corrupt[a] = 0;
        @(posedge clk);
        #1;

        // Reset state
        step();
        step();
        chk("reset_parity_error", obs_pe, 1'b0);
        reset = 1'b0;

        // Contention from reset: both write every cycle, grants alternate s1 first
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 1, i,     '1, $urandom);
            drive(1, 1, 0, 1, i + 8, '1, $urandom);
            step();
            chk($sformatf("contend%0d_s1_wait", i), obs_w[0], i % 2);
            chk($sformatf("contend%0d_s2_wait", i), obs_w[1], (i + 1) % 2);
        end

        // Fill the whole array from s1
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 1, 0, 1, a, '1, $urandom);
            step();
        end

        // Single-port write then read
        drive(0, 1, 0, 1, 5, 4'hF, 32'hDEADBEEF);
        step();
        chk("wr5_wait", obs_w[0], 1'b0);
        drive(0, 1, 1, 0, 5, '1, '0);
        step();
        chk("rd5_wait", obs_w[0], 1'b0);
        idle();
        step();
        chk("rd5_not_early", obs_v[0], 1'b0);
        step();
        chk("rd5_valid", obs_v[0], 1'b1);
        chk("rd5_data", obs_d[0], 32'hDEADBEEF);

        // Byte lanes
        drive(0, 1, 0, 1, 5, 4'h5, 32'h11223344);
        step();
        drive(0, 1, 1, 0, 5, '1, '0);
        step();
        idle();
        step();
        step();
        chk("lanes_valid", obs_v[0], 1'b1);
        chk("lanes_data", obs_d[0], 32'hDE22BE44);

        // Stalls with clken, then with reset_req
        stall_read("stall_clken", 1'b0);
        stall_read("stall_rreq", 1'b1);

        // Reset the cycle after an s2 read grant
        idle();
        drive(1, 1, 1, 0, 3, '1, '0);
        step();
        chk("rst_rd_grant_wait", obs_w[1], 1'b0);
        idle();
        reset = 1'b1;
        step();
        chk("rst_rd_no_valid0", obs_v[1], 1'b0);
        chk("rst_rd_data0", obs_d[1], '0);
        reset = 1'b0;
        step();
        chk("rst_rd_no_valid1", obs_v[1], 1'b0);
        step();
        chk("rst_rd_no_valid2", obs_v[1], 1'b0);
        drive(0, 1, 0, 1, 1, '1, $urandom);
        drive(1, 1, 0, 1, 2, '1, $urandom);
        step();
        chk("post_rst_tie_s1_wait", obs_w[0], 1'b0);
        chk("post_rst_tie_s2_wait", obs_w[1], 1'b1);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++)
                drive(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1),
                      $urandom, $urandom);
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
        clken     = 1'b1;
        reset_req = 1'b0;
        repeat (4) step();

`ifdef DESCRIPTOR_MEMORY_PARITY_EN
        // Parity: corrupt one stored bit of address 7 and read it back
        drive(0, 1, 0, 1, 7, '1, 32'hA5C3_0F17);
        step();
        idle();
        step();
        dut.mem[7][0][0] = ~dut.mem[7][0][0];
        mm[7][0]   = ~mm[7][0];
        corrupt[7] = 1;
        drive(0, 1, 1, 0, 7, '1, '0);
        step();
        idle();
        step();
        chk("par_before_valid", obs_pe, 1'b0);
        step();
        chk("par_valid", obs_v[0], 1'b1);
        chk("par_with_valid", obs_pe, 1'b1);
        step();
        step();
        chk("par_sticky", obs_pe, 1'b1);
        reset = 1'b1;
        step();
        chk("par_cleared_by_reset", obs_pe, 1'b0);
        reset = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
